// File: rtl/tile_fetch_pkg.sv
// Shared types and constants for the tile fetch controller and its address generator.
package tile_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tf_state_e;

   // Width of matrix dimensions and tile indices
   localparam int DimWidth      = 7;
   // Width of the optional backpressure stall counter
   localparam int StallCntWidth = 16;

endpackage

// File: rtl/tile_addr_gen.sv
// Tile row/column counters and tile base address for a row-major matrix walk.
// Address wraps modulo 2^AddrWidth; the counters only move on advance_i,
// so the address holds whenever the controller is stalled.
module tile_addr_gen
   import tile_fetch_pkg::*;
#(
   parameter int DataRows    = 4,
   parameter int DataColumns = 4,
   parameter int AddrWidth   = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 advance_i,
   input  logic [AddrWidth-1:0] base_i,
   input  logic [DimWidth-1:0]  cols_i,
   input  logic [DimWidth-1:0]  tile_rows_i,
   input  logic [DimWidth-1:0]  tile_cols_i,
   output logic                 last_o,
   output logic [DimWidth-1:0]  tr_o,
   output logic [DimWidth-1:0]  tc_o,
   output logic [AddrWidth-1:0] addr_o
);

   logic row_end;

   assign row_end = (tc_o == tile_cols_i - DimWidth'(1));
   assign last_o  = row_end && (tr_o == tile_rows_i - DimWidth'(1));

   // Element offset of tile (tr, tc): tr*DataRows full matrix rows plus tc*DataColumns elements
   assign addr_o = base_i + AddrWidth'(32'(tr_o) * 32'(DataRows) * 32'(cols_i)
                                      + 32'(tc_o) * 32'(DataColumns));

   // Row-major tile counter: column index wraps into the next tile row
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         tr_o <= '0;
         tc_o <= '0;
      end else if (advance_i) begin
         if (row_end) begin
            tc_o <= '0;
            tr_o <= tr_o + DimWidth'(1);
         end else begin
            tc_o <= tc_o + DimWidth'(1);
         end
      end
   end

endmodule

// File: rtl/tile_fetch_ctrl.sv
// Tile fetch controller: walks a row-major matrix tile by tile, drives the
// tile base address and row stride to a combinational-read memory, registers
// each tile and streams it downstream over valid/ready.
// Optional build macro TILE_FETCH_STALL_CNT_EN adds stall_cnt_o, a saturating
// count of backpressure cycles since the last accepted start.
module tile_fetch_ctrl
   import tile_fetch_pkg::*;
#(
   parameter int DataWidth   = 8,
   parameter int DataRows    = 4,
   parameter int DataColumns = 4,
   parameter int DataDepth   = 1024,
   parameter int AddrWidth   = $clog2(DataDepth)
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic                                        start_i,
   input  logic [AddrWidth-1:0]                        base_addr_i,
   input  logic [DimWidth-1:0]                         mat_rows_i,
   input  logic [DimWidth-1:0]                         mat_cols_i,
   output logic                                        busy_o,
   output logic                                        done_o,
   output logic                                        err_o,
   output logic [AddrWidth-1:0]                        mem_addr_o,
   output logic [DimWidth-1:0]                         matrix_col_o,
   input  logic [DataWidth*DataRows*DataColumns-1:0]   mem_rd_data_i,
   output logic [DataWidth*DataRows*DataColumns-1:0]   tile_o,
   output logic                                        tile_valid_o,
   input  logic                                        tile_ready_i,
`ifdef TILE_FETCH_STALL_CNT_EN
   output logic [StallCntWidth-1:0]                    stall_cnt_o,
`endif
   output logic [DimWidth-1:0]                         tile_row_o,
   output logic [DimWidth-1:0]                         tile_col_o
);

   localparam logic [DimWidth-1:0] RowsDim = DimWidth'(DataRows);
   localparam logic [DimWidth-1:0] ColsDim = DimWidth'(DataColumns);

   tf_state_e              state;
   logic [AddrWidth-1:0]   base_q;
   logic [DimWidth-1:0]    tile_rows_q;
   logic [DimWidth-1:0]    tile_cols_q;
   logic                   all_fetched;
   logic                   start_ok;
   logic                   dim_zero;
   logic                   dim_bad;
   logic                   fetch;
   logic                   take;
   logic                   advance;
   logic                   last;
   logic [DimWidth-1:0]    tr;
   logic [DimWidth-1:0]    tc;
   logic [AddrWidth-1:0]   gen_addr;

   assign start_ok = (state == IDLE) && start_i;
   assign dim_zero = (mat_rows_i == '0) || (mat_cols_i == '0);
   assign dim_bad  = ((mat_rows_i % RowsDim) != '0) || ((mat_cols_i % ColsDim) != '0);

   // Output register is free when empty or being accepted this cycle
   assign fetch   = (state == RUN) && (!tile_valid_o || tile_ready_i);
   assign take    = fetch && !all_fetched;
   // The counters stop on the last tile so its address holds until the stream ends
   assign advance = take && !last;

   assign mem_addr_o = (state == RUN) ? gen_addr : '0;

   tile_addr_gen #(
      .DataRows    (DataRows),
      .DataColumns (DataColumns),
      .AddrWidth   (AddrWidth)
   ) u_addr_gen (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (start_ok),
      .advance_i   (advance),
      .base_i      (base_q),
      .cols_i      (matrix_col_o),
      .tile_rows_i (tile_rows_q),
      .tile_cols_i (tile_cols_q),
      .last_o      (last),
      .tr_o        (tr),
      .tc_o        (tc),
      .addr_o      (gen_addr)
   );

   // Control FSM with registered status, tile capture and handshake outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         base_q       <= '0;
         matrix_col_o <= '0;
         tile_rows_q  <= '0;
         tile_cols_q  <= '0;
         all_fetched  <= 1'b0;
         tile_valid_o <= 1'b0;
         tile_o       <= '0;
         tile_row_o   <= '0;
         tile_col_o   <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  base_q       <= base_addr_i;
                  matrix_col_o <= mat_cols_i;
                  tile_rows_q  <= mat_rows_i / RowsDim;
                  tile_cols_q  <= mat_cols_i / ColsDim;
                  all_fetched  <= 1'b0;
                  err_o        <= 1'b0;
                  if (dim_zero) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else if (dim_bad) begin
                     err_o  <= 1'b1;
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     state  <= RUN;
                     busy_o <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (take) begin
                  tile_o       <= mem_rd_data_i;
                  tile_row_o   <= tr;
                  tile_col_o   <= tc;
                  tile_valid_o <= 1'b1;
                  if (last) begin
                     all_fetched <= 1'b1;
                  end
               end else if (fetch) begin
                  // Nothing left to fetch, so this is the last tile being accepted
                  tile_valid_o <= 1'b0;
                  busy_o       <= 1'b0;
                  done_o       <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef TILE_FETCH_STALL_CNT_EN
   // Saturating count of cycles where a tile waits on downstream
   always_ff @(posedge clk_i) begin
      if (rst_i || start_ok) begin
         stall_cnt_o <= '0;
      end else if (tile_valid_o && !tile_ready_i && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o + StallCntWidth'(1);
      end
   end
`endif

endmodule

// File: doc/tile_fetch_ctrl.md
Name: tile_fetch_ctrl

Overview:
Upstream read controller for single_port_memory.
- Walks a row-major matrix stored in memory as a grid of DataRows x DataColumns tiles, in row-major tile order.
- Drives the tile base address and row stride to the memory, and captures each combinational tile read into an output register.
- Streams tiles to the downstream compute array over a valid/ready handshake.

Parameters:
DataWidth, 8, element width in bits
DataRows, 4, tile height in elements
DataColumns, 4, tile width in elements
DataDepth, 1024, memory depth in elements
AddrWidth, $clog2(DataDepth), memory address width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
start_i  in  1  start pulse; accepted only in IDLE
base_addr_i  in  AddrWidth  element address of matrix (0,0)
mat_rows_i  in  7  matrix row count
mat_cols_i  in  7  matrix column count; also the row stride
busy_o  out  1  high in RUN
done_o  out  1  one-cycle pulse after the last tile handshake
err_o  out  1  sticky; dimension error on the last start
mem_addr_o  out  AddrWidth  tile base address to memory
matrix_col_o  out  7  stride to memory (latched mat_cols)
mem_rd_data_i  in  DataWidth x DataRows*DataColumns  combinational tile read, row-major
tile_o  out  DataWidth x DataRows*DataColumns  registered tile
tile_valid_o  out  1  tile_o valid
tile_ready_i  in  1  downstream accepts
tile_row_o  out  7  tile-row index of tile_o
tile_col_o  out  7  tile-column index of tile_o

Behaviour:
States: IDLE, RUN, DONE.

Reset (sync, active-high): state IDLE; all outputs 0; tile_o zeroed; counters cleared. Applies mid-operation; an in-flight tile is discarded.

IDLE, start_i=1:
- Latch base, rows, cols; clear err_o.
- If rows==0 or cols==0 -> DONE, no tiles.
- If rows%DataRows!=0 or cols%DataColumns!=0 -> err_o=1, DONE, no tiles.
- Otherwise -> RUN with tile counters tr=tc=0.

Address computation:
- mem_addr_o = base + tr*DataRows*cols + tc*DataColumns, modulo 2^AddrWidth (wrap allowed, no error).
- Outside RUN: mem_addr_o=0, matrix_col_o holds the latched cols.

RUN:
- Fetch condition: fetch = !tile_valid_o || tile_ready_i.
- On fetch with tiles remaining: tile_o <= mem_rd_data_i; tile_row_o/tile_col_o <= tr/tc; tile_valid_o <= 1; advance tc, wrapping to 0 and incrementing tr at cols/DataColumns.
- Throughput: one tile/cycle when tile_ready_i is held high.
- Backpressure: tile_valid_o && !tile_ready_i -> tile_o, indices and address all hold; no counter advance.
- Completion: after the last tile is fetched, no further fetch. When that tile handshakes, tile_valid_o <= 0 -> DONE.

DONE: done_o=1 for exactly one cycle -> IDLE. start_i in DONE or RUN is ignored.

Latency:
- start_i accepted at cycle t -> first tile_valid_o at t+2 (address driven in t+1, captured at end of t+1).
- Last handshake at cycle n -> done_o at n+1.

Handshake rules: tile_valid_o never deasserts without a handshake except on reset; tile_o is stable while valid && !ready.

Optional Feature:
Macro TILE_FETCH_STALL_CNT_EN.
- Defined: adds port stall_cnt_o (out, 16 bits). It counts cycles with tile_valid_o && !tile_ready_i, clears on an accepted start_i and on reset, and saturates at 0xFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package tile_fetch_pkg: state enum tf_state_e {IDLE, RUN, DONE}, DimWidth=7 constant, StallCntWidth=16 constant.
- Sub-module tile_addr_gen: holds the tr/tc counters and computes the address. Interface: advance_i, last_o, tr_o, tc_o, addr_o.

Test Plan:
- 8x8 at base 0, ready=1 -> mem_addr_o sequence 0,4,32,36; tiles (0,0),(0,1),(1,0),(1,1) on consecutive cycles; done_o 1 cycle after the 4th handshake.
- Same with ready low 3 cycles on tile 2 -> tile_o/tile_col_o=1 held stable 3 cycles; stall_cnt_o=3 when TILE_FETCH_STALL_CNT_EN.
- 6x8 start -> err_o=1, no tile_valid_o, done_o pulse 1 cycle after start; next valid start clears err_o.
- rows=0 -> done_o pulse, no tiles, err_o=0.
- base=1020, 4x8, DataDepth=1024 -> mem_addr_o 1020 then 0 (wrap).
- rst_i asserted with tile_valid_o=1 in RUN -> next cycle IDLE, tile_valid_o=0, busy_o=0, no done_o.
